lane_shooter_core: RTL

Parametrised game engine for the lane-shooter VGA demo. It holds enemy, bullet and player state in N_LANES horizontal lanes and advances that state on a synchronous movement tick. It resolves hits, tracks score and lives, and produces the registered 12-bit pixel colour for the VGA timing generator. It replaces the fixed 4-lane, free-running-clock game logic with a single-clock-domain, fully reset design.

---
 rtl/lane_shooter_core.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lane_shooter_core.sv
// lane_shooter_core: lane-shooter game engine. It holds the enemy, bullet and
// player state, steps it on each movement tick, and renders a registered RGB444 pixel.
// Ports:
//   clk_25mHz, rst          pixel clock, async active-high reset
//   tick                    one-cycle movement strobe
//   btn_up/down/trigger     debounced button levels
//   rand_lane               random spawn lane (taken modulo N_LANES)
//   pixel_xpos/ypos         current pixel coordinates
//   pixel_data              registered colour, 1-cycle latency
//   score, lives            game counters
//   game_state              00 IDLE, 01 PLAY, 10 OVER
//   miss_pulse              one-cycle pulse after a tick in which an enemy escaped
module lane_shooter_core #(
    parameter int unsigned N_LANES    = 4,
    parameter int unsigned N_ENEMY    = 16,
    parameter int unsigned N_BULLET   = 10,
    parameter int unsigned STEP_X     = 100,
    parameter int unsigned SPRITE     = 100,
    parameter int unsigned LANE0_Y    = 16,
    parameter int unsigned LANE_PITCH = 116,
    parameter int unsigned START_X    = 20,
    parameter int unsigned END_X      = 520,
    parameter int unsigned LIVES      = 3
) (
    input  logic                       clk_25mHz,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_trigger,
    input  logic [$clog2(N_LANES)-1:0] rand_lane,
    input  logic [9:0]                 pixel_xpos,
    input  logic [9:0]                 pixel_ypos,
    output logic [11:0]                pixel_data,
    output logic [15:0]                score,
    output logic [3:0]                 lives,
    output logic [1:0]                 game_state,
    output logic                       miss_pulse
);
    localparam int unsigned LW  = $clog2(N_LANES);
    localparam int unsigned EW  = $clog2(N_ENEMY + 1);
    localparam int unsigned EIW = $clog2(N_ENEMY);
    localparam int unsigned BIW = $clog2(N_BULLET);
    localparam logic signed [10:0] HIT_WIN = 11'(2 * STEP_X);

    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;

    state_t            state;
    logic [N_ENEMY-1:0]  e_exist;
    logic [LW-1:0]       e_lane [N_ENEMY];
    logic [9:0]          e_x    [N_ENEMY];
    logic [N_BULLET-1:0] b_exist;
    logic [LW-1:0]       b_lane [N_BULLET];
    logic [9:0]          b_x    [N_BULLET];
    logic [LW-1:0]       player_lane;
    logic                cooldown, pending;
    logic                up_prev, down_prev, trig_prev;
    logic                up_edge, down_edge, trig_edge;

    assign up_edge    = btn_up & ~up_prev;
    assign down_edge  = btn_down & ~down_prev;
    assign trig_edge  = btn_trigger & ~trig_prev;
    assign game_state = state;

    function automatic logic [9:0] lane_y(input logic [LW-1:0] l);
        return 10'(LANE0_Y + LANE_PITCH * 32'(l));
    endfunction

    function automatic logic covers(input logic [9:0] ox, input logic [9:0] oy,
                                    input logic [9:0] px, input logic [9:0] py);
        return ({1'b0, px} >= {1'b0, ox}) && ({1'b0, px} < 11'(ox) + 11'(SPRITE)) &&
               ({1'b0, py} >= {1'b0, oy}) && ({1'b0, py} < 11'(oy) + 11'(SPRITE));
    endfunction

    // Tick result: hit, move, spawn, all against pre-tick positions
    logic [N_ENEMY-1:0]  e_hit, n_e_exist;
    logic [N_BULLET-1:0] b_hit, n_b_exist;
    logic [LW-1:0]       n_e_lane [N_ENEMY];
    logic [9:0]          n_e_x    [N_ENEMY];
    logic [9:0]          n_b_x    [N_BULLET];
    logic [EW-1:0]       hit_cnt, esc_cnt;
    logic [3:0]          n_lives;
    logic [15:0]         n_score;
    logic [16:0]         score_sum;
    logic signed [10:0]  diff;
    logic [10:0]         nx;
    logic [EIW-1:0]      spawn_idx;
    logic                spawn_ok;

    always_comb begin
        e_hit     = '0;
        b_hit     = '0;
        n_e_lane  = e_lane;
        n_e_x     = e_x;
        n_b_x     = b_x;
        hit_cnt   = '0;
        esc_cnt   = '0;
        diff      = '0;
        nx        = '0;
        spawn_idx = '0;
        spawn_ok  = 1'b0;
        for (int e = 0; e < int'(N_ENEMY); e++) begin
            for (int b = 0; b < int'(N_BULLET); b++) begin
                diff = $signed({1'b0, b_x[b]}) - $signed({1'b0, e_x[e]});
                if (e_exist[e] && b_exist[b] && e_lane[e] == b_lane[b] &&
                    diff >= 11'sd0 && diff < HIT_WIN) begin
                    e_hit[e] = 1'b1;
                    b_hit[b] = 1'b1;
                end
            end
        end
        n_e_exist = e_exist & ~e_hit;
        n_b_exist = b_exist & ~b_hit;
        for (int e = 0; e < int'(N_ENEMY); e++) begin
            if (e_hit[e]) hit_cnt = hit_cnt + EW'(1);
            nx = {1'b0, e_x[e]} + 11'(STEP_X);
            if (n_e_exist[e]) begin
                if (nx >= 11'(END_X)) begin
                    n_e_exist[e] = 1'b0;
                    esc_cnt      = esc_cnt + EW'(1);
                end else begin
                    n_e_x[e] = nx[9:0];
                end
            end
        end
        for (int b = 0; b < int'(N_BULLET); b++) begin
            if (n_b_exist[b]) begin
                if (b_x[b] <= 10'(START_X + STEP_X - 1)) n_b_exist[b] = 1'b0;
                else                                     n_b_x[b] = b_x[b] - 10'(STEP_X);
            end
        end
        n_lives   = (32'(esc_cnt) >= 32'(lives)) ? 4'd0 : lives - 4'(esc_cnt);
        score_sum = 17'(score) + 17'(hit_cnt);
        n_score   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        // Lowest free slot wins: scan downward so the last hit is the lowest
        for (int e = int'(N_ENEMY) - 1; e >= 0; e--) begin
            if (!n_e_exist[e]) begin
                spawn_idx = EIW'(e);
                spawn_ok  = 1'b1;
            end
        end
        if (spawn_ok && n_lives != 4'd0) begin
            n_e_exist[spawn_idx] = 1'b1;
            n_e_x[spawn_idx]     = 10'(START_X);
            n_e_lane[spawn_idx]  = LW'(32'(rand_lane) % N_LANES);
        end
    end

    // Lowest free bullet slot for a fire request
    logic [BIW-1:0] fire_idx;
    logic           fire_ok;

    always_comb begin
        fire_idx = '0;
        fire_ok  = 1'b0;
        for (int b = int'(N_BULLET) - 1; b >= 0; b--) begin
            if (!b_exist[b]) begin
                fire_idx = BIW'(b);
                fire_ok  = 1'b1;
            end
        end
    end

    // Render: player > bullet > enemy > background
    logic [11:0] pix_c;
    logic        on_enemy, on_bullet, on_player;

    always_comb begin
        on_enemy  = 1'b0;
        on_bullet = 1'b0;
        on_player = covers(10'(END_X), lane_y(player_lane), pixel_xpos, pixel_ypos);
        for (int e = 0; e < int'(N_ENEMY); e++)
            if (e_exist[e] && covers(e_x[e], lane_y(e_lane[e]), pixel_xpos, pixel_ypos))
                on_enemy = 1'b1;
        for (int b = 0; b < int'(N_BULLET); b++)
            if (b_exist[b] && covers(b_x[b], lane_y(b_lane[b]), pixel_xpos, pixel_ypos))
                on_bullet = 1'b1;
        pix_c = (state == OVER) ? 12'hFFF : 12'h000;
        if      (on_player) pix_c = 12'h0F0;
        else if (on_bullet) pix_c = 12'h00F;
        else if (on_enemy)  pix_c = 12'hF00;
    end

    always_ff @(posedge clk_25mHz or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            e_exist     <= '0;
            b_exist     <= '0;
            for (int i = 0; i < int'(N_ENEMY); i++) begin
                e_lane[i] <= '0;
                e_x[i]    <= '0;
            end
            for (int i = 0; i < int'(N_BULLET); i++) begin
                b_lane[i] <= '0;
                b_x[i]    <= '0;
            end
            player_lane <= '0;
            cooldown    <= 1'b0;
            pending     <= 1'b0;
            up_prev     <= 1'b0;
            down_prev   <= 1'b0;
            trig_prev   <= 1'b0;
            pixel_data  <= '0;
            score       <= '0;
            lives       <= 4'(LIVES);
            miss_pulse  <= 1'b0;
        end else begin
            up_prev    <= btn_up;
            down_prev  <= btn_down;
            trig_prev  <= btn_trigger;
            pixel_data <= pix_c;
            miss_pulse <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (trig_edge) begin
                        e_exist     <= '0;
                        b_exist     <= '0;
                        cooldown    <= 1'b0;
                        pending     <= 1'b0;
                        score       <= '0;
                        lives       <= 4'(LIVES);
                        player_lane <= '0;
                        state       <= PLAY;
                    end
                end
                PLAY: begin
                    if (up_edge && !down_edge && player_lane != LW'(N_LANES - 1))
                        player_lane <= player_lane + LW'(1);
                    else if (down_edge && !up_edge && player_lane != '0)
                        player_lane <= player_lane - LW'(1);
                    if (tick) begin
                        e_exist    <= n_e_exist;
                        e_lane     <= n_e_lane;
                        e_x        <= n_e_x;
                        b_exist    <= n_b_exist;
                        b_x        <= n_b_x;
                        score      <= n_score;
                        lives      <= n_lives;
                        miss_pulse <= (esc_cnt != '0);
                        cooldown   <= 1'b0;
                        // A trigger coinciding with a tick is serviced next cycle
                        pending    <= pending | trig_edge;
                        if (n_lives == 4'd0) state <= OVER;
                    end else begin
                        pending <= 1'b0;
                        if ((trig_edge || pending) && !cooldown && fire_ok) begin
                            b_exist[fire_idx] <= 1'b1;
                            b_lane[fire_idx]  <= player_lane;
                            b_x[fire_idx]     <= 10'(END_X - STEP_X);
                            cooldown          <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
